scan_decoder: RTL
=================

Name: scan_decoder

Overview:
- Receive side of the multiplexed 4-digit seven-segment scan bus driven by the clock display logic.
- Samples the active-low anode strobes and active-low segment lines, reconstructs the four BCD digits, and flags malformed patterns.
- Used as an on-chip loopback monitor for the alarm-clock display.
- Also used as the front end of a remote/secondary display board fed by the same scan wires.

Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before a digit is accepted (legal range ≥1).
- SYNC_STAGES, 2, flip-flop depth of the input synchronizer (legal range ≥2).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- segments_in  input  7  segment lines a..g on bits [0]..[6], active-low (0 = lit); asynchronous to clk.
- anode_in  input  4  digit strobes, active-low one-hot; bit0 = rightmost digit; asynchronous to clk.
- digit0..digit3  output  4 each  decoded digit per anode position; 4'hE = "H" pattern.
- digit_valid  output  4  bit n set once digitn has been captured since reset.
- frame_done  output  1  one-cycle pulse when all four positions are captured in the current frame.
- err  output  1  one-cycle pulse on a stable illegal pattern.

Behaviour:
- Reset (rst = 0, asynchronous): synchronizer flops, stability counter, seen mask, digit0..3, digit_valid, frame_done and err all clear to 0.
- Synchronizer:
  - All 11 input bits pass through SYNC_STAGES flops.
  - The last stage feeds a compare register holding the previous sample.
- Stability counter:
  - Width $clog2(STABLE_CYCLES+1); saturates at STABLE_CYCLES.
  - Resets to 1 whenever the synchronized sample differs from the previous sample; otherwise increments.
- Accept event:
  - Fires on the clock edge where the counter reaches STABLE_CYCLES.
  - Fires exactly once per stable run; the counter holds, and a further accept requires a new sample change.
  - Latency: an input that settles before edge t is registered at edge t+SYNC_STAGES+STABLE_CYCLES-1.
- Anode classification at accept:
  - 4'b1111: blank. Nothing updates and err stays low.
  - Exactly one bit low: legal; the position is the index of that bit.
  - More than one bit low: err pulses. No digit or mask update.
- Segment decode (active-low pattern, bit0 = a):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4.
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9.
  - 1001000→4'hE.
  - Any other pattern: err pulses. No digit or mask update.
- Legal accept:
  - digit[pos] is loaded with the decoded value and digit_valid[pos] is set.
  - The seen mask bit [pos] is set.
  - A repeated position within a frame overwrites the digit; the mask is unchanged.
- Frame FSM, states COLLECT and DONE:
  - COLLECT→DONE on the edge where the mask becomes 4'b1111.
  - In DONE, frame_done = 1 for exactly one cycle. The mask clears and the FSM returns to COLLECT; an accept in that same cycle is applied to the cleared mask.
- err and frame_done are registered, one-cycle pulses. They may coincide only if distinct events occur in the same cycle, which cannot happen by construction. err never coincides with a digit update.
- Reset mid-run: all state is discarded; a partial frame never produces frame_done.

Decomposition:
- Shared package: SEG_* active-low segment constants (0–9, H), ANODE_BLANK = 4'b1111, and the frame state enum {COLLECT, DONE}.
- The same SEG_* constants serve the encoder side, so both directions use one table.
- One natural sub-module, seg_pattern_decode: combinational 7-bit pattern → {valid, 4-bit digit}.

Test Plan:
- Reset then idle (anode 1111, segments 1111111 for 100 cycles) -> digit_valid = 0, frame_done and err never assert.
- Scan 1,2,3,4 onto anodes 1110/1101/1011/0111, each held 20 cycles -> digit0..3 = 1,2,3,4; digit_valid = 1111; single frame_done pulse after the 4th accept, at latency 5 from settle with defaults.
- Glitch: segments toggle between two values every 2 cycles for 30 cycles, STABLE_CYCLES = 4 -> no accept, no err, digits unchanged.
- Illegal inputs: anode 1100 held 10 cycles -> one err pulse, no update; segments 1111110 on anode 1110 -> one err pulse, digit0 unchanged.
- Repeat position: anode 1110 shows 7, then 9, then 1101/1011/0111 -> digit0 = 9; frame_done pulses once, only after all four positions are seen.
- Assert rst mid-frame after 3 positions, then scan positions 2 and 3 only -> all outputs 0 during reset; no frame_done afterward; digit_valid = 1100.

Source files
------------

// File: rtl/scan_decoder_pkg.sv
// Shared definitions for the seven-segment scan bus: active-low segment table,
// blank strobe value, decode result and frame state.
package scan_decoder_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned ANODE_W    = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned POS_W      = $clog2(NUM_DIGITS);

  // Active-low patterns, bit0 = segment a, so literals read g..a left to right.
  localparam logic [SEG_W-1:0] SEG_0 = 7'b100_0000;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b111_1001;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b010_0100;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b011_0000;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b001_1001;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b001_0010;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b000_0010;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b111_1000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b000_0000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b001_0000;
  localparam logic [SEG_W-1:0] SEG_H = 7'b000_1001;

  localparam logic [ANODE_W-1:0] ANODE_BLANK = 4'b1111;
  localparam logic [DIGIT_W-1:0] DIGIT_H     = 4'hE;

  typedef enum logic {COLLECT, DONE} frame_state_e;

  typedef struct packed {
    logic               valid;
    logic [DIGIT_W-1:0] digit;
  } seg_decode_t;

  typedef struct packed {
    logic [ANODE_W-1:0] anode;
    logic [SEG_W-1:0]   seg;
  } scan_sample_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern to digit lookup; unknown patterns
// come back with valid low.
module seg_pattern_decode
  import scan_decoder_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output seg_decode_t      result_c
);

  always_comb begin
    result_c.valid = 1'b1;
    result_c.digit = '0;
    case (pattern)
      SEG_0:   result_c.digit = 4'd0;
      SEG_1:   result_c.digit = 4'd1;
      SEG_2:   result_c.digit = 4'd2;
      SEG_3:   result_c.digit = 4'd3;
      SEG_4:   result_c.digit = 4'd4;
      SEG_5:   result_c.digit = 4'd5;
      SEG_6:   result_c.digit = 4'd6;
      SEG_7:   result_c.digit = 4'd7;
      SEG_8:   result_c.digit = 4'd8;
      SEG_9:   result_c.digit = 4'd9;
      SEG_H:   result_c.digit = DIGIT_H;
      default: result_c.valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/scan_decoder.sv
// Receive side of the multiplexed 4-digit seven-segment scan bus: synchronizes
// the strobes, waits for a stable pattern, and rebuilds the four digits.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEG_W-1:0]   segments_in,
  input  logic [ANODE_W-1:0] anode_in,
  output logic [DIGIT_W-1:0] digit0,
  output logic [DIGIT_W-1:0] digit1,
  output logic [DIGIT_W-1:0] digit2,
  output logic [DIGIT_W-1:0] digit3,
  output logic [ANODE_W-1:0] digit_valid,
  output logic               frame_done,
  output logic               err
);

  localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  scan_sample_t          sync_q [SYNC_STAGES];
  scan_sample_t          prev_q;
  scan_sample_t          sample_c;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_next_c;
  logic                  changed_c;
  logic                  accept_c;
  logic                  blank_c;
  logic                  anode_legal_c;
  logic [POS_W-1:0]      pos_c;
  logic [ANODE_W-1:0]    pos_mask_c;
  logic                  legal_c;
  logic                  illegal_c;
  logic [ANODE_W-1:0]    mask_q;
  logic [ANODE_W-1:0]    mask_next_c;
  logic [DIGIT_W-1:0]    digit_q [NUM_DIGITS];
  frame_state_e          state_q;
  seg_decode_t           dec_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= '{anode: anode_in, seg: segments_in};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sample_c  = sync_q[SYNC_STAGES-1];
  assign changed_c = (sample_c != prev_q);

  // Accept once per stable run, including a fresh run when STABLE_CYCLES is 1.
  always_comb begin
    if (changed_c)            cnt_next_c = CNT_W'(1);
    else if (cnt_q == CNT_MAX) cnt_next_c = cnt_q;
    else                      cnt_next_c = cnt_q + CNT_W'(1);
    accept_c = (cnt_next_c == CNT_MAX) && (changed_c || (cnt_q != CNT_MAX));
  end

  seg_pattern_decode u_decode (
    .pattern  (sample_c.seg),
    .result_c (dec_c)
  );

  always_comb begin
    pos_c = '0;
    for (int unsigned i = 0; i < ANODE_W; i++) begin
      if (!sample_c.anode[i]) pos_c = POS_W'(i);
    end
    blank_c       = (sample_c.anode == ANODE_BLANK);
    anode_legal_c = $onehot(~sample_c.anode);
    pos_mask_c    = ANODE_W'(1) << pos_c;
    legal_c       = accept_c && anode_legal_c && dec_c.valid;
    illegal_c     = accept_c && !blank_c && !(anode_legal_c && dec_c.valid);
    mask_next_c   = mask_q | (legal_c ? pos_mask_c : '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q      <= '0;
      cnt_q       <= '0;
      mask_q      <= '0;
      state_q     <= COLLECT;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
    end else begin
      prev_q     <= sample_c;
      cnt_q      <= cnt_next_c;
      err        <= illegal_c;
      frame_done <= 1'b0;
      if (legal_c) begin
        digit_q[pos_c]     <= dec_c.digit;
        digit_valid[pos_c] <= 1'b1;
      end
      // DONE lasts one cycle; an accept landing there starts the next frame.
      case (state_q)
        COLLECT: begin
          mask_q <= mask_next_c;
          if (mask_next_c == '1) begin
            state_q    <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          mask_q  <= legal_c ? pos_mask_c : '0;
          state_q <= COLLECT;
        end
      endcase
    end
  end

  assign digit0 = digit_q[0];
  assign digit1 = digit_q[1];
  assign digit2 = digit_q[2];
  assign digit3 = digit_q[3];

endmodule
